// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fir_pkg
// Purpose  : Shared types and constants for the 4-tap Q1.15 FIR pipeline and
//            its coefficient configuration controller.
// Contents : DATA_W, NTAPS, FIR_LATENCY, COEF_RST, coef_t, ctrl_state_t
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int DATA_W      = 16;
  localparam int NTAPS       = 4;
  // valid_in-to-valid_out latency of the FIR datapath
  localparam int FIR_LATENCY = 3;
  // 0.25 in Q1.15
  localparam logic [DATA_W-1:0] COEF_RST = 16'h2000;

  typedef logic signed [DATA_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SWAP = 2'd2
  } ctrl_state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_coef_ctrl
// Purpose  : Double-buffered coefficient controller for the FIR datapath.
//            Host writes land in a shadow bank; a commit holds off upstream
//            samples, waits for the pipeline to drain, then copies shadow to
//            active in a single cycle so no output mixes coefficient sets.
// Ports    : clk, rst_n (async, active-low)
//            cfg_we/cfg_addr/cfg_wdata  - shadow write
//            cfg_commit                 - request shadow-to-active swap
//            cfg_busy, cfg_err          - commit in progress / rejected access
//            sample_valid               - FIR valid_in monitor
//            hold_out                   - stall request to the sample source
//            coef_out, coef_update      - active bank and change pulse
//            commit_cnt                 - completed swaps (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module fir_coef_ctrl #(
  parameter int                DATA_W       = fir_pkg::DATA_W,
  parameter int                NTAPS        = fir_pkg::NTAPS,
  parameter int                DRAIN_CYCLES = fir_pkg::FIR_LATENCY,
  parameter logic [DATA_W-1:0] COEF_RST     = fir_pkg::COEF_RST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_addr,
  input  logic [DATA_W-1:0]       cfg_wdata,
  input  logic                    cfg_commit,
  output logic                    cfg_busy,
  output logic                    cfg_err,
  input  logic                    sample_valid,
  output logic                    hold_out,
  output logic [NTAPS*DATA_W-1:0] coef_out,
  output logic                    coef_update,
  output logic [7:0]              commit_cnt
);

  import fir_pkg::*;

  localparam int          CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q [NTAPS];
  logic [DATA_W-1:0] shadow_d [NTAPS];
  logic [DATA_W-1:0] active_q [NTAPS];
  logic [DATA_W-1:0] active_d [NTAPS];
  logic [7:0]        commit_cnt_q, commit_cnt_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              update_q, update_d;
  logic              addr_bad;

  // A 2-bit address can only fall outside the bank when fewer than 4 taps exist.
  generate
    if (NTAPS < 4) begin : g_addr_chk
      assign addr_bad = ({1'b0, cfg_addr} >= 3'(NTAPS));
    end else begin : g_addr_full
      assign addr_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    commit_cnt_d = commit_cnt_q;
    err_d        = 1'b0;
    update_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < NTAPS; k++) begin
              if (int'(cfg_addr) == k) shadow_d[k] = cfg_wdata;
            end
          end
        end
        // A same-cycle write is already in shadow_d, so the swap picks it up.
        if (cfg_commit) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end

      HOLD: begin
        err_d = cfg_we | cfg_commit;
        // Any sample seen restarts the drain window: it may have been in
        // flight upstream when hold was raised.
        if (sample_valid) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = SWAP;
        end
      end

      SWAP: begin
        err_d        = cfg_we | cfg_commit;
        active_d     = shadow_q;
        commit_cnt_d = commit_cnt_q + 8'd1;
        update_d     = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    hold_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      commit_cnt_q <= '0;
      hold_q       <= 1'b0;
      err_q        <= 1'b0;
      update_q     <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= COEF_RST;
        active_q[k] <= COEF_RST;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      commit_cnt_q <= commit_cnt_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      update_q     <= update_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  generate
    for (genvar k = 0; k < NTAPS; k++) begin : g_pack
      assign coef_out[k*DATA_W +: DATA_W] = active_q[k];
    end
  endgenerate

  assign hold_out    = hold_q;
  assign cfg_busy    = hold_q;
  assign cfg_err     = err_q;
  assign coef_update = update_q;
  assign commit_cnt  = commit_cnt_q;

endmodule : fir_coef_ctrl
`default_nettype wire
